// File: rtl/simon_seq_ctrl.sv
// simon_seq_ctrl: Simon Says sequencer that plays a seed-derived colour sequence and checks the player's presses.
// Optional WAIT_IN inactivity timeout is built when SIMON_TIMEOUT_EN is defined.
module simon_seq_ctrl #(
  parameter int MAX_ROUNDS     = 16,
  parameter int ON_CYCLES      = 50,
  parameter int GAP_CYCLES     = 25,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] seed,
  input  logic [3:0]  btn,
  output logic        seed_rst,
  output logic [3:0]  led,
  output logic [4:0]  round,
  output logic        busy,
  output logic        fail,
  output logic        win
);
  typedef enum logic [2:0] {IDLE, PAUSE, SHOW_ON, SHOW_GAP, WAIT_IN, S_FAIL, S_WIN} state_t;
  state_t state, state_n;
  logic [15:0] tmr, tmr_n;
  logic [31:0] seed_q, seed_q_n;
  logic [3:0]  idx, idx_n, want;
  logic [4:0]  round_n;
  logic [1:0]  colour;
  logic        seed_rst_n, last_step, on_end, gap_end;
  if (MAX_ROUNDS < 1 || MAX_ROUNDS > 16 || ON_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad
    $error("simon_seq_ctrl: illegal parameter value");
  end
  assign colour    = 2'(seed_q >> {idx, 1'b0});
  assign want      = 4'b0001 << colour;
  assign last_step = {1'b0, idx} + 5'd1 == round;
  assign on_end    = tmr == 16'(ON_CYCLES - 1);
  assign gap_end   = tmr == 16'(GAP_CYCLES - 1);
  assign busy      = state inside {PAUSE, SHOW_ON, SHOW_GAP, WAIT_IN};
  assign fail      = state == S_FAIL;
  assign win       = state == S_WIN;
`ifdef SIMON_TIMEOUT_EN
  logic [15:0] tout, tout_n;
  logic        expired;
  assign expired = tout == 16'(TIMEOUT_CYCLES - 1);
`endif
  always_comb begin
    state_n    = state;
    tmr_n      = tmr + 16'd1;
    idx_n      = idx;
    round_n    = round;
    seed_q_n   = seed_q;
    seed_rst_n = 1'b0;
    led        = '0;
`ifdef SIMON_TIMEOUT_EN
    tout_n     = state == WAIT_IN ? tout + 16'd1 : '0;
`endif
    case (state)
      IDLE, S_FAIL, S_WIN: begin
        led   = state == S_WIN ? 4'b1111 : 4'b0000;
        tmr_n = '0;
        if (start) begin
          state_n    = PAUSE;
          seed_q_n   = seed;
          round_n    = 5'd1;
          idx_n      = '0;
          seed_rst_n = 1'b1;
        end
      end
      PAUSE: if (gap_end) begin
        state_n = SHOW_ON;
        tmr_n   = '0;
        idx_n   = '0;
      end
      SHOW_ON: begin
        led = want;
        if (on_end) begin
          state_n = SHOW_GAP;
          tmr_n   = '0;
        end
      end
      SHOW_GAP: if (gap_end) begin
        tmr_n   = '0;
        state_n = last_step ? WAIT_IN : SHOW_ON;
        idx_n   = last_step ? 4'd0 : idx + 4'd1;
      end
      WAIT_IN: begin
        led   = btn;
        tmr_n = '0;
        // want is one-hot, so equality alone rejects idle and multi-hot input
        if (btn == want) begin
`ifdef SIMON_TIMEOUT_EN
          tout_n = '0;
`endif
          if (!last_step) idx_n = idx + 4'd1;
          else if (round == 5'(MAX_ROUNDS)) state_n = S_WIN;
          else begin
            round_n = round + 5'd1;
            idx_n   = '0;
            state_n = PAUSE;
          end
        end else if (btn != '0) state_n = S_FAIL;
`ifdef SIMON_TIMEOUT_EN
        else if (expired) state_n = S_FAIL;
`endif
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tmr      <= '0;
      idx      <= '0;
      round    <= '0;
      seed_q   <= '0;
      seed_rst <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
      tout     <= '0;
`endif
    end else begin
      state    <= state_n;
      tmr      <= tmr_n;
      idx      <= idx_n;
      round    <= round_n;
      seed_q   <= seed_q_n;
      seed_rst <= seed_rst_n;
`ifdef SIMON_TIMEOUT_EN
      tout     <= tout_n;
`endif
    end
  end
endmodule

// File: tb/tb_simon_seq_ctrl.sv
// tb_simon_seq_ctrl: self-checking bench for simon_seq_ctrl with MAX_ROUNDS=3, ON=4, GAP=2, TIMEOUT=20.
module tb_simon_seq_ctrl;
  localparam int MR = 3, ON = 4, GAP = 2, TO = 20;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [31:0] seed = '0;
  logic [3:0] btn = '0;
  logic seed_rst, busy, fail, win;
  logic [3:0] led;
  logic [4:0] round;
  int n_chk = 0, n_fail = 0;

  simon_seq_ctrl #(.MAX_ROUNDS(MR), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .btn(btn),
    .seed_rst(seed_rst), .led(led), .round(round), .busy(busy), .fail(fail), .win(win));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] b;
    logic       f;
    logic       bz;
    logic [4:0] r;
    logic [3:0] l;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input logic [31:0] s, input int i);
    logic [31:0] d = 1;
    for (int k = 0; k < i; k++) d = d * 4;
    return 4'b0001 << ((s / d) % 4);
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic start_game(input logic [31:0] s);
    seed  = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    seed  = $urandom;
    chk("start_busy", busy, 1);
    chk("start_round", round, 1);
    chk("start_fail", fail, 0);
    chk("start_win", win, 0);
  endtask

  task automatic play_round(input logic [31:0] s, input int r);
    logic [3:0] q[$];
    repeat (GAP) q.push_back(4'b0000);
    for (int i = 0; i < r; i++) begin
      repeat (ON) q.push_back(onehot(s, i));
      repeat (GAP) q.push_back(4'b0000);
    end
    chk("play_round", round, r);
    foreach (q[j]) begin
      btn = 4'($urandom_range(0, 15));
      #1;
      chk("play_led", led, q[j]);
      chk("play_busy", busy, 1);
      chk("play_seed_rst", seed_rst, (r == 1 && j == 0) ? 1 : 0);
      tick();
    end
    btn = '0;
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    #1;
    chk("press_led_mirror", led, b);
    tick();
    btn = '0;
    #1;
  endtask

  task automatic run_game(input logic [31:0] s, input int wr, input int wi, input logic [3:0] wb);
    logic [3:0] b;
    start_game(s);
    for (int r = 1; r <= MR; r++) begin
      play_round(s, r);
      for (int i = 0; i < r; i++) begin
        repeat ($urandom_range(0, 3)) begin
          start = ($urandom_range(0, 2) == 0);
          seed  = ~s;
          #1;
          chk("idle_led", led, 0);
          chk("idle_busy", busy, 1);
          chk("idle_seed_rst", seed_rst, 0);
          tick();
          start = 1'b0;
        end
        b = (r == wr && i == wi) ? wb : onehot(s, i);
        press(b);
        chk("press_round_or_hold", round, (b == onehot(s, i) && i == r - 1 && r < MR) ? r + 1 : r);
        chk("press_seed_rst", seed_rst, 0);
        if (b != onehot(s, i)) begin
          chk("wrong_fail", fail, 1);
          chk("wrong_busy", busy, 0);
          chk("wrong_led", led, 0);
          return;
        end
        if (i == r - 1 && r == MR) begin
          chk("win_flag", win, 1);
          chk("win_led", led, 4'b1111);
          chk("win_busy", busy, 0);
          chk("win_fail", fail, 0);
        end else begin
          chk("ok_busy", busy, 1);
          chk("ok_fail", fail, 0);
        end
      end
    end
  endtask

  initial begin
    vec_t vt[7];
    vt[0] = '{b: 4'b0001, f: 1'b0, bz: 1'b1, r: 5'd2, l: 4'b0000};
    vt[1] = '{b: 4'b0000, f: 1'b0, bz: 1'b1, r: 5'd1, l: 4'b0000};
    vt[2] = '{b: 4'b0010, f: 1'b1, bz: 1'b0, r: 5'd1, l: 4'b0000};
    vt[3] = '{b: 4'b0011, f: 1'b1, bz: 1'b0, r: 5'd1, l: 4'b0000};
    vt[4] = '{b: 4'b0100, f: 1'b1, bz: 1'b0, r: 5'd1, l: 4'b0000};
    vt[5] = '{b: 4'b1000, f: 1'b1, bz: 1'b0, r: 5'd1, l: 4'b0000};
    vt[6] = '{b: 4'b1111, f: 1'b1, bz: 1'b0, r: 5'd1, l: 4'b0000};
    #2;
    chk("rst_led", led, 0);
    chk("rst_round", round, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fail", fail, 0);
    chk("rst_win", win, 0);
    chk("rst_seed_rst", seed_rst, 0);
    tick();
    tick();
    reset = 1'b1;
    run_game(32'h0000_00E4, 0, 0, 4'b0000);
    chk("full_win_round", round, 3);
    run_game(32'h0000_00E4, 2, 1, 4'b0100);
    chk("wrong_r2_round", round, 2);
    chk("wrong_r2_win", win, 0);
    for (int v = 0; v < 7; v++) begin
      do_reset();
      start_game(32'h0000_00E4);
      play_round(32'h0000_00E4, 1);
      press(vt[v].b);
      chk("vec_fail", fail, vt[v].f);
      chk("vec_busy", busy, vt[v].bz);
      chk("vec_round", round, vt[v].r);
      chk("vec_led", led, vt[v].l);
    end
    do_reset();
    start_game(32'h0000_00E4);
    repeat (GAP + 1) tick();
    chk("show_on_led", led, 4'b0001);
    reset = 1'b0;
    #1;
    chk("async_led", led, 0);
    chk("async_round", round, 0);
    chk("async_busy", busy, 0);
    chk("async_seed_rst", seed_rst, 0);
    chk("async_fail", fail, 0);
    chk("async_win", win, 0);
    reset = 1'b1;
    #1;
    start_game(32'h0000_00E4);
    play_round(32'h0000_00E4, 1);
`ifdef SIMON_TIMEOUT_EN
    repeat (TO - 1) tick();
    chk("timeout_not_yet", busy, 1);
    tick();
    chk("timeout_fail", fail, 1);
    chk("timeout_busy", busy, 0);
`else
    repeat (200) tick();
    chk("no_timeout_busy", busy, 1);
    chk("no_timeout_fail", fail, 0);
`endif
    do_reset();
    for (int g = 0; g < 15; g++) begin
      logic [31:0] s = $urandom;
      int wr = $urandom_range(0, MR);
      int wi = (wr == 0) ? 0 : $urandom_range(0, wr - 1);
      run_game(s, wr, wi, 4'($urandom_range(1, 15)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/simon_seq_ctrl.md
# simon_seq_ctrl

Game sequencer for the Simon Says core. It samples the 32-bit seed from the seed generator when a game starts and expands it into a colour sequence of up to 16 steps, two bits per step. Each round it plays the sequence on the LEDs, then checks the player's button presses against it. It reports round number and win/fail, and pulses the seed generator's reset so the next game samples a fresh value.

## Interface
Parameters:
- `MAX_ROUNDS`, default 16: rounds needed to win; legal range 1..16.
- `ON_CYCLES`, default 50: cycles an LED is lit per step; must be ≥1.
- `GAP_CYCLES`, default 25: dark cycles after each step and before each playback; must be ≥1.
- `TIMEOUT_CYCLES`, default 1000: idle cycles allowed between presses (`SIMON_TIMEOUT_EN` only).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a game.
- `seed`  in  32  current seed generator value.
- `btn`  in  4  debounced single-cycle press pulses, bit n = colour n.
- `seed_rst`  out  1  one-cycle pulse to the generator's rst_seedgen.
- `led`  out  4  one-hot colour display.
- `round`  out  5  current round, 1..MAX_ROUNDS; 0 when no game has run.
- `busy`  out  1  game in progress.
- `fail`  out  1  held high after a loss.
- `win`  out  1  held high after a win.

## Operation
- Reset: state IDLE. All outputs 0. `seed_q`, step index `idx` and timers are cleared.
- Step i colour is `seed_q[2i+1:2i]`. Colour c lights `led[c]`.
- IDLE, FAIL, WIN:
  - On `start`: latch `seed`→`seed_q`, set `round`=1, set `idx`=0, clear `fail`/`win`, go to PAUSE.
  - `seed_rst` pulses in the cycle after the latch.
- PAUSE: `led`=0 for GAP_CYCLES cycles, then SHOW_ON with `idx`=0.
- SHOW_ON: `led`=onehot(colour[idx]) for ON_CYCLES cycles, then SHOW_GAP.
- SHOW_GAP: `led`=0 for GAP_CYCLES cycles.
  - If `idx`+1==`round`: go to WAIT_IN with `idx`=0.
  - Otherwise: `idx`++ and go to SHOW_ON.
- WAIT_IN: `led` mirrors `btn` for that cycle.
  - `btn`==0: no action.
  - Exactly one bit set and equal to onehot(colour[idx]): a correct press, handled as follows.
    - If `idx`+1<`round`: `idx`++ and clear the timeout timer.
    - Else if `round`==MAX_ROUNDS: go to WIN.
    - Else: `round`++ and go to PAUSE.
  - Multi-hot or wrong colour: go to FAIL.
- FAIL: `fail`=1, `led`=0.
- WIN: `win`=1, `led`=4'b1111.
- `busy`=1 in PAUSE, SHOW_ON, SHOW_GAP and WAIT_IN.
- `start` while `busy` is ignored.
- `btn` outside WAIT_IN is ignored and not queued.
- `round` holds its last value in FAIL and WIN.

## Timing
- `start` sampled at edge k: `busy`=1 and state PAUSE from k+1; first LED lit at k+1+GAP_CYCLES.
- Playback of round r lasts r·(ON_CYCLES+GAP_CYCLES) cycles after the PAUSE.
- A press sampled at edge m takes effect at m+1: state, `idx`, `fail`, `win`, `round`.
- `seed` is sampled on the same edge as `start`. `seed_rst` is high for exactly the following cycle.
- Timers count from 0 and expire on count == N−1, so each phase is exactly N cycles.
- `reset` low mid-game: all state and outputs return to reset values immediately (asynchronous). No `seed_rst` pulse is produced.
- A correct final press and a timeout expiry in the same cycle: the press wins.

## Configuration
- `SIMON_TIMEOUT_EN` defined:
  - WAIT_IN counts cycles with no press.
  - Reaching TIMEOUT_CYCLES goes to FAIL on the next edge.
  - The counter clears on every correct press and on entry to WAIT_IN.
- `SIMON_TIMEOUT_EN` undefined: WAIT_IN waits indefinitely. The timeout counter and the TIMEOUT_CYCLES logic are not built.

## Test plan
Bench parameters for all scenarios: MAX_ROUNDS=3, ON_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20, `seed`=32'h0000_00E4, giving colours 0, 1, 2.

- Reset then `start`:
  - `seed_rst` high for exactly 1 cycle after start.
  - `busy`=1.
  - `led`=0 for 2 cycles, then 4'b0001 for 4 cycles, then 0 for 2 cycles.
  - Enters WAIT_IN with `round`=1.
- Full win:
  - Press 0; then 0,1; then 0,1,2, each after its playback.
  - Round 2 shows 0001 then 0010; round 3 shows 0001, 0010, 0100.
  - After the last press: `win`=1, `led`=1111, `busy`=0, `round`=3.
- Wrong press: in round 2, press 0 then `btn`=4'b0100 → `fail`=1, `led`=0, `round`=2 on the next edge.
- Multi-hot or ignored input:
  - `btn`=4'b0011 in WAIT_IN → FAIL.
  - `btn` pulses during SHOW_ON → no state change.
- Timeout (macro defined): no press for 20 cycles in WAIT_IN → `fail`=1. With the macro undefined, the same stimulus leaves `busy`=1 after 200 cycles.
- Asynchronous reset:
  - Drive `reset` low mid-SHOW_ON → all outputs 0 without a clock edge.
  - `start` in FAIL → new game with `round`=1 and `fail` cleared.
